// File: rtl/ext_pkg.sv
// ----------------------------------------------------------------------------
// ext_pkg
//   Shared definitions for the immediate-extension slice.
//   - ext_op_t    : extension op encodings carried on in_op
//   - ext_entry_t : one buffered result {data, tag} at the default widths
//   - EXT_*_W     : default widths used by the stage and its users
// ----------------------------------------------------------------------------
package ext_pkg;

  localparam int EXT_IN_W  = 16;
  localparam int EXT_OUT_W = 32;
  localparam int EXT_TAG_W = 5;

  typedef enum logic [1:0] {
    EXT_ZERO   = 2'b00,
    EXT_UPPER  = 2'b01,
    EXT_SIGN   = 2'b10,
    EXT_BRANCH = 2'b11
  } ext_op_t;

  typedef struct packed {
    logic [EXT_OUT_W-1:0] data;
    logic [EXT_TAG_W-1:0] tag;
  } ext_entry_t;

endpackage

// File: rtl/imm_ext_core.sv
// ----------------------------------------------------------------------------
// imm_ext_core
//   Purely combinational immediate extender.
//   Ports:
//     imm  in  IN_W   raw immediate
//     op   in  2      extension op (ext_op_t encoding)
//     data out OUT_W  extended immediate
//   Config macro: EXT_BRANCH_MODE_EN
//     defined   -> op BRANCH yields the sign-extended value shifted left by 2
//     undefined -> op BRANCH yields the plain sign-extended value
// ----------------------------------------------------------------------------
module imm_ext_core
  import ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  imm,
  input  logic [1:0]       op,
  output logic [OUT_W-1:0] data
);

  localparam int PAD_W = OUT_W - IN_W;

  logic [OUT_W-1:0] sign_ext;

  assign sign_ext = {{PAD_W{imm[IN_W-1]}}, imm};

  // Select the extension; BRANCH drops the top two sign bits to keep OUT_W.
  always_comb begin
    data = '0;
    case (ext_op_t'(op))
      EXT_ZERO:   data = {{PAD_W{1'b0}}, imm};
      EXT_UPPER:  data = {imm, {PAD_W{1'b0}}};
      EXT_SIGN:   data = sign_ext;
`ifdef EXT_BRANCH_MODE_EN
      EXT_BRANCH: data = {sign_ext[OUT_W-3:0], 2'b00};
`else
      EXT_BRANCH: data = sign_ext;
`endif
      default:    data = '0;
    endcase
  end

endmodule

// File: rtl/imm_ext_stage.sv
// ----------------------------------------------------------------------------
// imm_ext_stage
//   ID-stage immediate extender registered into a 2-entry in-order skid buffer.
//   Ports:
//     clk, rst_n            clock, asynchronous active-low reset
//     flush                 synchronous drop of every buffered entry
//     in_valid / in_ready   upstream handshake; in_ready depends on count only
//     in_imm, in_op, in_tag raw immediate, extension op, sideband tag
//     out_valid / out_ready downstream handshake for the head entry
//     out_data, out_tag     head entry (entry0) contents
//   Config macro: EXT_BRANCH_MODE_EN (selects BRANCH shifting in imm_ext_core)
//   OUT_W must be greater than IN_W.
// ----------------------------------------------------------------------------
module imm_ext_stage
  import ext_pkg::*;
#(
  parameter int IN_W  = EXT_IN_W,
  parameter int OUT_W = EXT_OUT_W,
  parameter int TAG_W = EXT_TAG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
);

  // Same layout as ext_entry_t, sized by this instance's parameters.
  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic [TAG_W-1:0] tag;
  } entry_t;

  logic [1:0]       count, count_nxt;
  entry_t           entry0, entry1, entry0_nxt, entry1_nxt, new_entry;
  logic [OUT_W-1:0] ext_data;
  logic             push, pop;

  imm_ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .imm  (in_imm),
    .op   (in_op),
    .data (ext_data)
  );

  assign new_entry = '{data: ext_data, tag: in_tag};

  assign in_ready  = (count < 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_data  = entry0.data;
  assign out_tag   = entry0.tag;

  // Buffer update. Push+pop is only possible at count 1 (empty has no pop,
  // full has no push), so the new entry then replaces the head directly.
  // Flush only clears the count; stale entry contents are don't-care.
  always_comb begin
    count_nxt  = count;
    entry0_nxt = entry0;
    entry1_nxt = entry1;
    if (flush) begin
      count_nxt = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) entry0_nxt = new_entry;
          else               entry1_nxt = new_entry;
          count_nxt = count + 2'd1;
        end
        2'b01: begin
          entry0_nxt = entry1;
          count_nxt  = count - 2'd1;
        end
        2'b11: begin
          entry0_nxt = new_entry;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= 2'd0;
      entry0 <= '0;
      entry1 <= '0;
    end else begin
      count  <= count_nxt;
      entry0 <= entry0_nxt;
      entry1 <= entry1_nxt;
    end
  end

endmodule

// File: tb/tb_imm_ext_stage.sv
module tb_imm_ext_stage;

  import ext_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_imm;
  logic [1:0]  in_op;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_tag;

  logic        s_flush;
  logic        s_in_valid;
  logic        s_in_ready;
  logic [7:0]  s_in_imm;
  logic [1:0]  s_in_op;
  logic [4:0]  s_in_tag;
  logic        s_out_valid;
  logic        s_out_ready;
  logic [15:0] s_out_data;
  logic [4:0]  s_out_tag;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  tag;
  } exp_t;

  exp_t sb_q[$];
  exp_t sq[$];

  imm_ext_stage u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_imm    (in_imm),
    .in_op     (in_op),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
  );

  imm_ext_stage #(
    .IN_W  (8),
    .OUT_W (16),
    .TAG_W (5)
  ) u_small (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (s_flush),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
    .in_imm    (s_in_imm),
    .in_op     (s_in_op),
    .in_tag    (s_in_tag),
    .out_valid (s_out_valid),
    .out_ready (s_out_ready),
    .out_data  (s_out_data),
    .out_tag   (s_out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_miss++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Issue one transaction on the main instance; call at a negedge.
  task automatic apply_stimulus(input logic [15:0] imm, input logic [1:0] op,
                                input logic [4:0] tag, input logic [31:0] exp_data);
    int guard;
    exp_t e;
    guard    = 0;
    in_valid = 1'b1;
    in_imm   = imm;
    in_op    = op;
    in_tag   = tag;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      n_vec++;
      n_miss++;
      $display("[TB] FAIL push_timeout: in_ready stayed 0 for tag %0d, expected 1", tag);
    end else begin
      e.data = exp_data;
      e.tag  = tag;
      sb_q.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic apply_small(input logic [7:0] imm, input logic [1:0] op,
                             input logic [4:0] tag, input logic [15:0] exp_data);
    int guard;
    exp_t e;
    guard      = 0;
    s_in_valid = 1'b1;
    s_in_imm   = imm;
    s_in_op    = op;
    s_in_tag   = tag;
    while (!s_in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!s_in_ready) begin
      n_vec++;
      n_miss++;
      $display("[TB] FAIL small_push_timeout: in_ready stayed 0 for tag %0d, expected 1", tag);
    end else begin
      e.data = {16'h0000, exp_data};
      e.tag  = tag;
      sq.push_back(e);
    end
    @(negedge clk);
    s_in_valid = 1'b0;
  endtask

  // Main-instance monitor: samples between negedge and posedge; a handshake
  // seen here completes at the next posedge.
  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (rst_n && !flush && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("[TB] FAIL unexpected_out: got tag %0d data %h, expected no output", out_tag, out_data);
      end else begin
        e = sb_q.pop_front();
        check_output("out_data", out_data, e.data);
        check_output("out_tag", {27'd0, out_tag}, {27'd0, e.tag});
      end
    end
  end

  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (rst_n && s_out_valid && s_out_ready) begin
      if (sq.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("[TB] FAIL small_unexpected_out: got tag %0d data %h, expected no output", s_out_tag, s_out_data);
      end else begin
        e = sq.pop_front();
        check_output("small_out_data", {16'd0, s_out_data}, e.data);
        check_output("small_out_tag", {27'd0, s_out_tag}, {27'd0, e.tag});
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n       = 1'b0;
    flush       = 1'b0;
    in_valid    = 1'b0;
    in_imm      = '0;
    in_op       = '0;
    in_tag      = '0;
    out_ready   = 1'b0;
    s_flush     = 1'b0;
    s_in_valid  = 1'b0;
    s_in_imm    = '0;
    s_in_op     = '0;
    s_in_tag    = '0;
    s_out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check_output("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_output("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_output("rst_out_data", out_data, 32'd0);
    check_output("rst_out_tag", {27'd0, out_tag}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Op sweep
    out_ready = 1'b1;
    apply_stimulus(16'h8001, EXT_ZERO,   5'd1, 32'h0000_8001);
    apply_stimulus(16'h8001, EXT_UPPER,  5'd2, 32'h8001_0000);
    apply_stimulus(16'h8001, EXT_SIGN,   5'd3, 32'hFFFF_8001);
`ifdef EXT_BRANCH_MODE_EN
    apply_stimulus(16'h8001, EXT_BRANCH, 5'd4, 32'hFFFE_0004);
`else
    apply_stimulus(16'h8001, EXT_BRANCH, 5'd4, 32'hFFFF_8001);
`endif
    apply_stimulus(16'h7FFF, EXT_SIGN,   5'd5, 32'h0000_7FFF);
    repeat (3) @(negedge clk);

    // Stall: third push held off until downstream releases
    out_ready = 1'b0;
    apply_stimulus(16'h0011, EXT_ZERO, 5'd1, 32'h0000_0011);
    apply_stimulus(16'h0022, EXT_ZERO, 5'd2, 32'h0000_0022);
    fork
      apply_stimulus(16'h0033, EXT_ZERO, 5'd3, 32'h0000_0033);
      begin
        repeat (3) @(negedge clk);
        check_output("stall_in_ready", {31'd0, in_ready}, 32'd0);
        check_output("stall_head_tag", {27'd0, out_tag}, 32'd1);
        out_ready = 1'b1;
      end
    join
    repeat (4) @(negedge clk);

    // Push+pop at count 1 for 10 cycles
    out_ready = 1'b0;
    apply_stimulus(16'hFFFF, EXT_SIGN, 5'd10, 32'hFFFF_FFFF);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(16'(i * 16'h0101), EXT_UPPER, 5'(11 + i), {16'(i * 16'h0101), 16'h0000});
      check_output("pp_out_valid", {31'd0, out_valid}, 32'd1);
      check_output("pp_in_ready", {31'd0, in_ready}, 32'd1);
    end
    repeat (3) @(negedge clk);
    check_output("pp_drained", {31'd0, out_valid}, 32'd0);

    // Flush at count 2 with a push in the same cycle
    out_ready = 1'b0;
    apply_stimulus(16'h0A0A, EXT_ZERO, 5'd20, 32'h0000_0A0A);
    apply_stimulus(16'h0B0B, EXT_ZERO, 5'd21, 32'h0000_0B0B);
    in_valid = 1'b1;
    in_imm   = 16'hDEAD;
    in_op    = EXT_ZERO;
    in_tag   = 5'd31;
    flush    = 1'b1;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    sb_q.delete();
    check_output("flush_out_valid", {31'd0, out_valid}, 32'd0);
    check_output("flush_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    apply_stimulus(16'h1234, EXT_ZERO, 5'd22, 32'h0000_1234);
    repeat (3) @(negedge clk);

    // Asynchronous reset mid-clock at count 2
    out_ready = 1'b0;
    apply_stimulus(16'h5555, EXT_ZERO, 5'd23, 32'h0000_5555);
    apply_stimulus(16'h6666, EXT_ZERO, 5'd24, 32'h0000_6666);
    #1;
    rst_n = 1'b0;
    #1;
    check_output("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check_output("arst_out_data", out_data, 32'd0);
    check_output("arst_in_ready", {31'd0, in_ready}, 32'd1);
    sb_q.delete();
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    apply_stimulus(16'h00C3, EXT_SIGN, 5'd25, 32'h0000_00C3);
    check_output("arst_latency_valid", {31'd0, out_valid}, 32'd1);
    check_output("arst_latency_tag", {27'd0, out_tag}, 32'd25);
    repeat (3) @(negedge clk);

    // Narrow parameter variant
    apply_small(8'h7F, EXT_SIGN,  5'd1, 16'h007F);
    apply_small(8'hA5, EXT_UPPER, 5'd2, 16'hA500);
    apply_small(8'h80, EXT_SIGN,  5'd3, 16'hFF80);
    apply_small(8'h80, EXT_ZERO,  5'd4, 16'h0080);
    repeat (4) @(negedge clk);

    check_output("sb_empty", 32'(sb_q.size()), 32'd0);
    check_output("small_sb_empty", 32'(sq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
